hes_msg_feeder: RTL and testbench

Upstream input stage of the hash datapath. Accepts a byte stream with per-message framing, buffers it in a small FIFO and presents one byte at a time to the hash control stage through the `F_dr`/`F_rtr` handshake. It also generates the `start`, `case_rc0` and `End_of_File` framing signals that control stage consumes, and holds back the next message until `H_ready` reports the digest is complete.

---
 rtl/hes_pkg.sv | 23 ++
 rtl/hes_byte_fifo.sv | 46 ++++
 rtl/hes_msg_feeder.sv | 139 +++++++++++++
 tb/tb_hes_msg_feeder.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hes_pkg.sv
// Shared types for the hash message feeder: FSM states, FIFO entry layout, length-append size.
// HES_LEN_APPEND_EN adds the LEN state that appends a 64-bit big-endian byte count.
package hes_pkg;

    localparam int unsigned HES_LEN_BYTES = 8;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StStream = 3'd2,
`ifdef HES_LEN_APPEND_EN
        StLen    = 3'd3,
`endif
        StEof    = 3'd4
    } feeder_state_t;

    typedef struct packed {
        logic       empty;
        logic       last;
        logic [7:0] data;
    } feeder_entry_t;

endpackage

// File: rtl/hes_byte_fifo.sv
// Synchronous FIFO. The head entry is read straight from the storage registers
// and stays stable until it is popped.
module hes_byte_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // The extra pointer bit tells full from empty when the addresses match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/hes_msg_feeder.sv
// Input stage of the hash datapath: buffers framed bytes and feeds them one at a time.
// With HES_LEN_APPEND_EN defined, each non-empty message is followed by its 8-byte length.
module hes_msg_feeder
    import hes_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LEN_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    input  logic             in_empty,
    output logic             in_ready,
    input  logic             F_rtr,
    input  logic             H_ready,
    output logic             F_dr,
    output logic [7:0]       M_byte,
    output logic             start,
    output logic             case_rc0,
    output logic             End_of_File,
    output logic [LEN_W-1:0] msg_len
);

    feeder_state_t     state;
    logic [LEN_W-1:0]  msg_len_q;
    feeder_entry_t     wr_entry;
    feeder_entry_t     head;
    logic [9:0]        head_bits;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_wr;
    logic              fifo_rd;
    logic              hs;
`ifdef HES_LEN_APPEND_EN
    logic [2:0]        len_idx;
    logic [63:0]       len64;
`endif

    assign in_ready = !fifo_full && !rst;
    assign fifo_wr  = in_valid && in_ready;
    assign head     = feeder_entry_t'(head_bits);

    // An empty token carries no data; normalise its payload so the head is predictable.
    always_comb begin
        wr_entry       = '0;
        wr_entry.empty = in_empty;
        wr_entry.last  = in_last && !in_empty;
        wr_entry.data  = in_empty ? 8'h00 : in_data;
    end

    hes_byte_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(feeder_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data (wr_entry),
        .rd_en   (fifo_rd),
        .rd_data (head_bits),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        F_dr    = 1'b0;
        M_byte  = 8'h00;
        fifo_rd = 1'b0;
`ifdef HES_LEN_APPEND_EN
        len64                = '0;
        len64[LEN_W-1:0]     = msg_len_q;
`endif
        unique case (state)
            StStart: fifo_rd = head.empty;
            StStream: begin
                F_dr    = !fifo_empty;
                M_byte  = fifo_empty ? 8'h00 : head.data;
                fifo_rd = !fifo_empty && F_rtr;
            end
`ifdef HES_LEN_APPEND_EN
            StLen: begin
                F_dr   = 1'b1;
                M_byte = len64[{3'd7 - len_idx, 3'b000} +: 8];
            end
`endif
            default: ;
        endcase
    end

    assign hs          = F_dr && F_rtr;
    assign start       = (state == StStart);
    assign End_of_File = (state == StEof);
    assign msg_len     = msg_len_q;
    assign case_rc0    = (msg_len_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            msg_len_q <= '0;
`ifdef HES_LEN_APPEND_EN
            len_idx   <= '0;
`endif
        end else begin
            unique case (state)
                StIdle: if (!fifo_empty) state <= StStart;
                StStart: begin
                    msg_len_q <= '0;
                    state     <= head.empty ? StEof : StStream;
                end
                StStream: begin
                    if (hs) begin
                        msg_len_q <= msg_len_q + LEN_W'(1);
                        if (head.last) begin
`ifdef HES_LEN_APPEND_EN
                            state   <= StLen;
                            len_idx <= '0;
`else
                            state   <= StEof;
`endif
                        end
                    end
                end
`ifdef HES_LEN_APPEND_EN
                StLen: begin
                    if (hs) begin
                        len_idx <= len_idx + 1'b1;
                        if (len_idx == 3'(HES_LEN_BYTES - 1)) state <= StEof;
                    end
                end
`endif
                StEof: if (H_ready) state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_hes_msg_feeder.sv
// Self-checking bench for hes_msg_feeder: directed sequences plus a randomized run
// against a message-level reference model. Honours HES_LEN_APPEND_EN when defined.
module tb_hes_msg_feeder;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LEN_W = 32;
    localparam int unsigned NMSG  = 40;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_last;
    logic             in_empty;
    logic             in_ready;
    logic             F_rtr;
    logic             H_ready;
    logic             F_dr;
    logic [7:0]       M_byte;
    logic             start;
    logic             case_rc0;
    logic             End_of_File;
    logic [LEN_W-1:0] msg_len;

    int n_total = 0;
    int n_pass  = 0;

    hes_msg_feeder #(
        .DEPTH (DEPTH),
        .LEN_W (LEN_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_empty    (in_empty),
        .in_ready    (in_ready),
        .F_rtr       (F_rtr),
        .H_ready     (H_ready),
        .F_dr        (F_dr),
        .M_byte      (M_byte),
        .start       (start),
        .case_rc0    (case_rc0),
        .End_of_File (End_of_File),
        .msg_len     (msg_len)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    // Bytes the hash stage should see for a message: data, then the length field if enabled.
    task automatic build_exp(input logic [7:0] msg[$], output logic [7:0] q[$]);
        logic [63:0] l;
        q = msg;
        l = 64'(msg.size());
`ifdef HES_LEN_APPEND_EN
        if (msg.size() > 0)
            for (int k = 7; k >= 0; k--) q.push_back(l[k*8 +: 8]);
`endif
    endtask

    // Sends msg (from entry sent0) and drains it with F_rtr=1 until End_of_File or stop_after bytes.
    task automatic deliver(input logic [7:0] msg[$], input int stop_after, input int sent0,
                           input int got0);
        logic [7:0] exp[$];
        int n, m, sent, got, cyc, starts;
        build_exp(msg, exp);
        n = msg.size();
        m = (n == 0) ? 1 : n;
        sent = sent0;
        got = got0;
        cyc = 0;
        starts = 0;
        F_rtr = 1'b1;
        while (!End_of_File && got < stop_after && cyc < 200) begin
            in_valid = (sent < m);
            in_empty = (n == 0);
            in_data  = (sent < n) ? msg[sent] : 8'hA5;
            in_last  = (n == 0) ? 1'b1 : (sent == n - 1);
            if (start) starts++;
            if (F_dr && F_rtr) begin
                chk("deliver_byte", M_byte, (got < exp.size()) ? exp[got] : 8'hxx);
                got++;
            end
            if (in_valid && in_ready) sent++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        in_empty = 1'b0;
        F_rtr    = 1'b0;
        if (cyc >= 200) fail_now("deliver_timeout");
        else if (stop_after > exp.size()) begin
            chk("deliver_count", got, exp.size());
            chk("deliver_eof", End_of_File, 1);
            chk("deliver_len", msg_len, n);
            chk("deliver_rc0", case_rc0, n == 0);
            chk("deliver_fdr_eof", F_dr, 0);
            if (sent0 == 0) chk("deliver_starts", starts, 1);
        end
    endtask

    task automatic ack();
        H_ready = 1'b1;
        tick();
        H_ready = 1'b0;
        chk("ack_eof_low", End_of_File, 0);
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       hr;
        logic       fdr;
        logic [7:0] mb;
        logic       st;
        logic       eof;
        logic [7:0] len;
    } vec_t;

    initial begin
        logic [7:0] msg[$];
        vec_t tbl[9];

        rst = 1'b1; in_valid = 0; in_data = 0; in_last = 0; in_empty = 0;
        F_rtr = 0; H_ready = 0;
        tick();
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_fdr", F_dr, 0);
        chk("rst_mbyte", M_byte, 0);
        chk("rst_start", start, 0);
        chk("rst_rc0", case_rc0, 1);
        chk("rst_eof", End_of_File, 0);
        chk("rst_len", msg_len, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", in_ready, 1);

`ifndef HES_LEN_APPEND_EN
        // Cycle-by-cycle trace of {61,62,63} with F_rtr held high.
        tbl[0] = '{1, 8'h61, 0, 0, 0, 8'h00, 0, 0, 8'd0};
        tbl[1] = '{1, 8'h62, 0, 0, 0, 8'h00, 1, 0, 8'd0};
        tbl[2] = '{1, 8'h63, 1, 0, 1, 8'h61, 0, 0, 8'd0};
        tbl[3] = '{0, 8'h00, 0, 0, 1, 8'h62, 0, 0, 8'd1};
        tbl[4] = '{0, 8'h00, 0, 0, 1, 8'h63, 0, 0, 8'd2};
        tbl[5] = '{0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 8'd3};
        tbl[6] = '{0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 8'd3};
        tbl[7] = '{0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 8'd3};
        tbl[8] = '{0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'd3};
        for (int i = 0; i < 9; i++) begin
            in_valid = tbl[i].v; in_data = tbl[i].d; in_last = tbl[i].l;
            F_rtr = 1'b1; H_ready = tbl[i].hr;
            tick();
            chk($sformatf("tbl%0d_fdr", i), F_dr, tbl[i].fdr);
            chk($sformatf("tbl%0d_mbyte", i), M_byte, tbl[i].mb);
            chk($sformatf("tbl%0d_start", i), start, tbl[i].st);
            chk($sformatf("tbl%0d_eof", i), End_of_File, tbl[i].eof);
            chk($sformatf("tbl%0d_len", i), msg_len, tbl[i].len);
            chk($sformatf("tbl%0d_rc0", i), case_rc0, tbl[i].len == 0);
            chk($sformatf("tbl%0d_ready", i), in_ready, 1);
        end
        in_valid = 0; in_last = 0; F_rtr = 0; H_ready = 0;
`else
        msg = '{8'h61, 8'h62, 8'h63};
        deliver(msg, 1000, 0, 0);
        ack();
        // Two-byte message: 10 20 then 00 00 00 00 00 00 00 02.
        msg = '{8'h10, 8'h20};
        deliver(msg, 1000, 0, 0);
        ack();
`endif

        // Zero-length message token.
        msg = {};
        deliver(msg, 1000, 0, 0);
        ack();

        // Backpressure: six bytes into a four-entry FIFO with the reader stalled.
        msg = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        for (int c = 0; c < 4; c++) begin
            in_valid = 1; in_data = msg[c]; in_last = 0;
            chk("bp_ready_fill", in_ready, 1);
            tick();
        end
        in_data = msg[4];
        chk("bp_ready_full", in_ready, 0);
        for (int c = 0; c < 3; c++) tick();
        chk("bp_ready_still_low", in_ready, 0);
        chk("bp_fdr_held", F_dr, 1);
        chk("bp_head_first", M_byte, 8'hA0);
        F_rtr = 1'b1;
        tick();
        F_rtr = 1'b0;
        chk("bp_ready_recover", in_ready, 1);
        chk("bp_head_second", M_byte, 8'hA1);
        deliver(msg, 1000, 4, 1);
        ack();

        // Next message arrives during EOF and must wait for H_ready.
        msg = '{8'h31, 8'h32};
        deliver(msg, 1000, 0, 0);
        in_valid = 1; in_data = 8'h55; in_last = 1;
        chk("eof_wr_ready", in_ready, 1);
        tick();
        in_valid = 0; in_last = 0;
        for (int c = 0; c < 4; c++) begin
            chk("eof_hold_start", start, 0);
            chk("eof_hold_eof", End_of_File, 1);
            tick();
        end
        H_ready = 1;
        tick();
        H_ready = 0;
        chk("eof_idle_start", start, 0);
        chk("eof_idle_eof", End_of_File, 0);
        tick();
        chk("eof_next_start", start, 1);
        tick();
        chk("eof_next_len0", msg_len, 0);
        chk("eof_next_fdr", F_dr, 1);
        chk("eof_next_byte", M_byte, 8'h55);
        msg = '{8'h55};
        deliver(msg, 1000, 1, 0);
        ack();

        // Reset after the first of three bytes is consumed.
        msg = '{8'h11, 8'h22, 8'h33};
        deliver(msg, 1, 0, 0);
        rst = 1;
        tick();
        chk("mrst_in_ready", in_ready, 0);
        chk("mrst_fdr", F_dr, 0);
        chk("mrst_mbyte", M_byte, 0);
        chk("mrst_start", start, 0);
        chk("mrst_rc0", case_rc0, 1);
        chk("mrst_eof", End_of_File, 0);
        chk("mrst_len", msg_len, 0);
        rst = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("mrst_flushed_start", start, 0);
            chk("mrst_flushed_fdr", F_dr, 0);
        end
        msg = '{8'h44, 8'h55};
        deliver(msg, 1000, 0, 0);
        ack();

        run_random();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Randomized traffic against a message-level model: a queue of entries to send,
    // a queue of bytes the reader must see, and per-message lengths.
    task automatic run_random();
        logic [9:0] ent_q[$];
        logic [7:0] exp_bytes[$];
        int lens[$];
        int occ, cur_len, cur_left, delivered, done, cyc;
        bit in_msg, eof_st, next_eof;
        logic [63:0] l;

        for (int i = 0; i < NMSG; i++) begin
            int len = $urandom_range(0, 6);
            lens.push_back(len);
            if (len == 0) ent_q.push_back(10'h200);
            for (int b = 0; b < len; b++) begin
                logic [7:0] d = 8'($urandom);
                ent_q.push_back({1'b0, b == len - 1, d});
                exp_bytes.push_back(d);
            end
`ifdef HES_LEN_APPEND_EN
            l = 64'(len);
            if (len > 0) for (int k = 7; k >= 0; k--) exp_bytes.push_back(l[k*8 +: 8]);
`else
            l = 64'(len);
`endif
        end

        occ = 0; cur_len = 0; cur_left = 0; delivered = 0; done = 0; cyc = 0;
        in_msg = 0; eof_st = 0;
        while (done < NMSG && cyc < 20000) begin
            in_valid = (ent_q.size() > 0) && ($urandom_range(0, 3) != 0);
            if (in_valid) begin
                in_empty = ent_q[0][9];
                in_last  = ent_q[0][9] ? 1'($urandom) : ent_q[0][8];
                in_data  = ent_q[0][9] ? 8'($urandom) : ent_q[0][7:0];
            end else begin
                in_empty = 1'($urandom);
                in_last  = 1'($urandom);
                in_data  = 8'($urandom);
            end
            F_rtr   = ($urandom_range(0, 2) != 0);
            H_ready = ($urandom_range(0, 3) == 0);
            next_eof = 0;

            chk("rnd_in_ready", in_ready, occ < DEPTH);
            chk("rnd_eof", End_of_File, eof_st);
            chk("rnd_rc0", case_rc0, msg_len == 0);
            if (eof_st) chk("rnd_eof_len", msg_len, cur_len);
            if (start) begin
                chk("rnd_start_between_msgs", in_msg, 0);
                in_msg = 1;
                cur_len = lens.pop_front();
`ifdef HES_LEN_APPEND_EN
                cur_left = cur_len + ((cur_len > 0) ? 8 : 0);
`else
                cur_left = cur_len;
`endif
                delivered = 0;
                if (cur_len == 0) begin
                    occ--;
                    next_eof = 1;
                end
            end
            if (F_dr) chk("rnd_fdr_in_msg", in_msg && !start && !eof_st, 1);
            if (F_dr && F_rtr) begin
                chk("rnd_byte", M_byte, (exp_bytes.size() > 0) ? exp_bytes.pop_front() : 8'hxx);
                if (delivered < cur_len) occ--;
                delivered++;
                cur_left--;
                if (cur_left == 0) next_eof = 1;
            end
            if (in_valid && in_ready) begin
                void'(ent_q.pop_front());
                occ++;
            end
            if (eof_st && H_ready) begin
                eof_st = 0;
                in_msg = 0;
                done++;
            end
            if (next_eof) eof_st = 1;
            tick();
            cyc++;
        end
        in_valid = 0; F_rtr = 0; H_ready = 0;
        if (cyc >= 20000) fail_now("rnd_timeout");
        chk("rnd_all_done", done, NMSG);
        chk("rnd_all_bytes", exp_bytes.size(), 0);
    endtask

endmodule
